// File: rtl/vec_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pipe_pkg
// Brief    : Shared types and helpers for the vector ALU pipeline
//            forwarding/hazard logic.
// Revision : 1.0 - initial release
// ============================================================================
package vec_pipe_pkg;

    // Operand source, encoded as seen on the debug outputs
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_IMM = 2'd3
    } fwd_src_e;

    // Load-use hazard controller state
    typedef enum logic [0:0] {
        HZ_IDLE  = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    // Width of the extra-bubble counter (covers up to two bubbles)
    localparam int c_cnt_w = 2;

    // Bit offset of lane 'lane' inside a packed vector of 'lane_w'-bit lanes
    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_lane_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : vec_lane_fwd_mux
// Brief    : One lane of operand forwarding. MEM result beats WB result,
//            which beats the register-file read data.
// Revision : 1.0 - initial release
// ============================================================================
module vec_lane_fwd_mux
    import vec_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_mem_hit,
    input  logic              i_wb_hit,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data,
    output fwd_src_e          o_src
);

    // Priority select: youngest in-flight result wins
    always_comb begin
        o_data = i_rf_data;
        o_src  = FWD_RF;
        if (i_mem_hit) begin
            o_data = i_mem_data;
            o_src  = FWD_MEM;
        end else if (i_wb_hit) begin
            o_data = i_wb_data;
            o_src  = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vec_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : vec_fwd_hazard_unit
// Brief    : ID->EX forwarding and load-use hazard unit for the vector ALU.
//            Resolves both operands per lane from MEM/WB (lane masks
//            honoured), applies the immediate on operand B, registers the
//            result into EX and stalls ID on load-use hazards.
// Revision : 1.0 - initial release
// ============================================================================
module vec_fwd_hazard_unit
    import vec_pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LANES        = 4,
    parameter int REG_AW       = 4,
    parameter int LOAD_BUBBLES = 1,
    parameter int ZERO_REG     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_ra,
    input  logic [REG_AW-1:0]       id_rb,
    input  logic [DATA_W*LANES-1:0] id_ra_data,
    input  logic [DATA_W*LANES-1:0] id_rb_data,
    input  logic                    id_imm_en,
    input  logic [DATA_W*LANES-1:0] id_imm,
    input  logic [REG_AW-1:0]       id_dest,
    input  logic                    id_we,
    input  logic                    id_is_load,
    input  logic [REG_AW-1:0]       mem_dest,
    input  logic                    mem_we,
    input  logic [LANES-1:0]        mem_wmask,
    input  logic [DATA_W*LANES-1:0] mem_res,
    input  logic                    mem_is_load,
    input  logic [REG_AW-1:0]       wb_dest,
    input  logic                    wb_we,
    input  logic [LANES-1:0]        wb_wmask,
    input  logic [DATA_W*LANES-1:0] wb_res,
    output logic                    stall,
    output logic                    ex_valid,
    output logic [DATA_W*LANES-1:0] ex_opa,
    output logic [DATA_W*LANES-1:0] ex_opb,
    output logic [REG_AW-1:0]       ex_dest,
    output logic                    ex_we,
    output logic                    ex_is_load,
    output logic [1:0]              fwd_a,
    output logic [1:0]              fwd_b
);

    localparam int                 c_vw    = DATA_W * LANES;
    localparam logic [c_cnt_w-1:0] c_extra = c_cnt_w'(LOAD_BUBBLES - 1);

    hz_state_e            r_state;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 r_ex_valid;
    logic [c_vw-1:0]      r_ex_opa;
    logic [c_vw-1:0]      r_ex_opb;
    logic [REG_AW-1:0]    r_ex_dest;
    logic                 r_ex_we;
    logic                 r_ex_is_load;
    logic [1:0]           r_fwd_a;
    logic [1:0]           r_fwd_b;

    logic                 w_ra_zero;
    logic                 w_rb_zero;
    logic                 w_mem_fwd_ok;
    logic                 w_mem_match_a;
    logic                 w_mem_match_b;
    logic                 w_wb_match_a;
    logic                 w_wb_match_b;
    logic [c_vw-1:0]      w_opa_fwd;
    logic [c_vw-1:0]      w_opb_fwd;
    logic [c_vw-1:0]      w_opb;
    logic [LANES-1:0][1:0] w_src_a;
    logic [LANES-1:0][1:0] w_src_b;
    logic [1:0]           w_fwd_b;
    logic                 w_unused_src;
    logic                 w_load_in_ex;
    logic                 w_hz_a;
    logic                 w_hz_b;
    logic                 w_hazard;
    logic                 w_issue;

    // Register 0 is a constant when ZERO_REG is set: never forwarded or checked
    assign w_ra_zero = (ZERO_REG != 0) && (id_ra == '0);
    assign w_rb_zero = (ZERO_REG != 0) && (id_rb == '0);

    // With two load bubbles the load data is not available yet in MEM
    assign w_mem_fwd_ok  = mem_we && !(mem_is_load && (LOAD_BUBBLES == 2));
    assign w_mem_match_a = w_mem_fwd_ok && (mem_dest == id_ra) && !w_ra_zero;
    assign w_mem_match_b = w_mem_fwd_ok && (mem_dest == id_rb) && !w_rb_zero;
    assign w_wb_match_a  = wb_we && (wb_dest == id_ra) && !w_ra_zero;
    assign w_wb_match_b  = wb_we && (wb_dest == id_rb) && !w_rb_zero;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int c_lsb = lane_lsb(l, DATA_W);

        vec_lane_fwd_mux #(.DATA_W(DATA_W)) u_mux_a (
            .i_mem_hit  (w_mem_match_a && mem_wmask[l]),
            .i_wb_hit   (w_wb_match_a && wb_wmask[l]),
            .i_rf_data  (id_ra_data[c_lsb +: DATA_W]),
            .i_mem_data (mem_res[c_lsb +: DATA_W]),
            .i_wb_data  (wb_res[c_lsb +: DATA_W]),
            .o_data     (w_opa_fwd[c_lsb +: DATA_W]),
            .o_src      (w_src_a[l])
        );

        vec_lane_fwd_mux #(.DATA_W(DATA_W)) u_mux_b (
            .i_mem_hit  (w_mem_match_b && mem_wmask[l]),
            .i_wb_hit   (w_wb_match_b && wb_wmask[l]),
            .i_rf_data  (id_rb_data[c_lsb +: DATA_W]),
            .i_mem_data (mem_res[c_lsb +: DATA_W]),
            .i_wb_data  (wb_res[c_lsb +: DATA_W]),
            .o_data     (w_opb_fwd[c_lsb +: DATA_W]),
            .o_src      (w_src_b[l])
        );
    end

    // Only lane 0's source is reported; the other lanes' sources are debug-only
    assign w_unused_src = ^{w_src_a, w_src_b};

    assign w_opb   = id_imm_en ? id_imm : w_opb_fwd;
    assign w_fwd_b = id_imm_en ? FWD_IMM : w_src_b[0];

    // Load-use: the EX instruction is a writing load whose dest we read
    assign w_load_in_ex = r_ex_valid && r_ex_is_load && r_ex_we;
    assign w_hz_a       = (r_ex_dest == id_ra) && !w_ra_zero;
    assign w_hz_b       = !id_imm_en && (r_ex_dest == id_rb) && !w_rb_zero;
    assign w_hazard     = (r_state == HZ_IDLE) && w_load_in_ex && id_valid &&
                          (w_hz_a || w_hz_b);

    assign stall   = !flush && ((r_state == HZ_STALL) || w_hazard);
    assign w_issue = id_valid && !stall && !flush;

    // Hazard FSM: extra bubbles beyond the first are counted down in STALL
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= HZ_IDLE;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= HZ_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                HZ_IDLE: begin
                    if (w_hazard && (LOAD_BUBBLES == 2)) begin
                        r_state <= HZ_STALL;
                        r_cnt   <= c_extra;
                    end
                end
                HZ_STALL: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                    if (r_cnt <= c_cnt_w'(1)) begin
                        r_state <= HZ_IDLE;
                    end
                end
                default: begin
                    r_state <= HZ_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ID->EX pipeline register; operands hold when nothing issues
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_opa     <= '0;
            r_ex_opb     <= '0;
            r_ex_dest    <= '0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_fwd_a      <= '0;
            r_fwd_b      <= '0;
        end else if (w_issue) begin
            r_ex_valid   <= 1'b1;
            r_ex_opa     <= w_opa_fwd;
            r_ex_opb     <= w_opb;
            r_ex_dest    <= id_dest;
            r_ex_we      <= id_we;
            r_ex_is_load <= id_is_load;
            r_fwd_a      <= w_src_a[0];
            r_fwd_b      <= w_fwd_b;
        end else begin
            r_ex_valid   <= 1'b0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_opa     = r_ex_opa;
    assign ex_opb     = r_ex_opb;
    assign ex_dest    = r_ex_dest;
    assign ex_we      = r_ex_we;
    assign ex_is_load = r_ex_is_load;
    assign fwd_a      = r_fwd_a;
    assign fwd_b      = r_fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_vec_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_fwd_hazard_unit
// Brief    : Scoreboard bench for vec_fwd_hazard_unit. Two instances
//            (LOAD_BUBBLES=1 and 2) share the stimulus; a reference model
//            predicts each cycle and a monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_fwd_hazard_unit;

    localparam int c_dw = 32;
    localparam int c_ln = 4;
    localparam int c_vw = c_dw * c_ln;

    typedef struct packed {
        logic            rst;
        logic            flush;
        logic            id_valid;
        logic [3:0]      id_ra;
        logic [3:0]      id_rb;
        logic [c_vw-1:0] id_ra_data;
        logic [c_vw-1:0] id_rb_data;
        logic            id_imm_en;
        logic [c_vw-1:0] id_imm;
        logic [3:0]      id_dest;
        logic            id_we;
        logic            id_is_load;
        logic [3:0]      mem_dest;
        logic            mem_we;
        logic [3:0]      mem_wmask;
        logic [c_vw-1:0] mem_res;
        logic            mem_is_load;
        logic [3:0]      wb_dest;
        logic            wb_we;
        logic [3:0]      wb_wmask;
        logic [c_vw-1:0] wb_res;
    } stim_t;

    // What the model believes EX holds, plus extra bubbles still owed
    typedef struct packed {
        logic            ex_valid;
        logic            ex_we;
        logic            ex_ld;
        logic [3:0]      ex_dest;
        logic [c_vw-1:0] opa;
        logic [c_vw-1:0] opb;
        logic [1:0]      fa;
        logic [1:0]      fb;
        logic [1:0]      extra;
    } mstate_t;

    typedef struct packed {
        logic    chk_stall;
        logic    stall;
        mstate_t s;
    } exp_t;

    typedef exp_t [1:0] pair_t;

    logic    clk = 1'b0;
    stim_t   cur = '0;
    mstate_t ms [2];
    logic    known = 1'b0;
    pair_t   q [$];
    int      n_chk = 0;
    int      n_fail = 0;

    logic            stall_o [2];
    logic            exv_o   [2];
    logic            exwe_o  [2];
    logic            exld_o  [2];
    logic [3:0]      exd_o   [2];
    logic [c_vw-1:0] opa_o   [2];
    logic [c_vw-1:0] opb_o   [2];
    logic [1:0]      fa_o    [2];
    logic [1:0]      fb_o    [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        vec_fwd_hazard_unit #(.LOAD_BUBBLES(k + 1)) u_dut (
            .clk         (clk),
            .rst         (cur.rst),
            .flush       (cur.flush),
            .id_valid    (cur.id_valid),
            .id_ra       (cur.id_ra),
            .id_rb       (cur.id_rb),
            .id_ra_data  (cur.id_ra_data),
            .id_rb_data  (cur.id_rb_data),
            .id_imm_en   (cur.id_imm_en),
            .id_imm      (cur.id_imm),
            .id_dest     (cur.id_dest),
            .id_we       (cur.id_we),
            .id_is_load  (cur.id_is_load),
            .mem_dest    (cur.mem_dest),
            .mem_we      (cur.mem_we),
            .mem_wmask   (cur.mem_wmask),
            .mem_res     (cur.mem_res),
            .mem_is_load (cur.mem_is_load),
            .wb_dest     (cur.wb_dest),
            .wb_we       (cur.wb_we),
            .wb_wmask    (cur.wb_wmask),
            .wb_res      (cur.wb_res),
            .stall       (stall_o[k]),
            .ex_valid    (exv_o[k]),
            .ex_opa      (opa_o[k]),
            .ex_opb      (opb_o[k]),
            .ex_dest     (exd_o[k]),
            .ex_we       (exwe_o[k]),
            .ex_is_load  (exld_o[k]),
            .fwd_a       (fa_o[k]),
            .fwd_b       (fb_o[k])
        );
    end

    task automatic cmp(input string nm, input int k, input logic [c_vw-1:0] act,
                       input logic [c_vw-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    // Lane-by-lane operand resolution straight from the forwarding rules
    function automatic logic [c_vw-1:0] resolve(input int lb, input logic [3:0] addr,
                                                input logic [c_vw-1:0] rf,
                                                input stim_t s, output logic [1:0] src0);
        logic [c_vw-1:0] r;
        logic [1:0]      src;
        r    = rf;
        src0 = 2'd0;
        for (int l = 0; l < c_ln; l++) begin
            src = 2'd0;
            if (addr != 0) begin
                if (s.mem_we && s.mem_dest == addr && s.mem_wmask[l] &&
                    !(s.mem_is_load && lb == 2))
                    src = 2'd1;
                else if (s.wb_we && s.wb_dest == addr && s.wb_wmask[l])
                    src = 2'd2;
            end
            if (src == 2'd1) r[l*c_dw +: c_dw] = s.mem_res[l*c_dw +: c_dw];
            if (src == 2'd2) r[l*c_dw +: c_dw] = s.wb_res[l*c_dw +: c_dw];
            if (l == 0) src0 = src;
        end
        return r;
    endfunction

    task automatic model_step(input int k, input int lb, input stim_t s, output exp_t e);
        mstate_t    m;
        logic       hz;
        logic       stl;
        logic [1:0] sa;
        logic [1:0] sb;
        m  = ms[k];
        sb = 2'd3;
        hz = (m.extra == 0) && m.ex_valid && m.ex_ld && m.ex_we && s.id_valid &&
             ((s.id_ra != 0 && s.id_ra == m.ex_dest) ||
              (!s.id_imm_en && s.id_rb != 0 && s.id_rb == m.ex_dest));
        stl = !s.flush && (m.extra != 0 || hz);
        e.chk_stall = known;
        e.stall     = stl;
        if (!s.rst) begin
            m = '0;
        end else begin
            if (s.flush)           m.extra = 2'd0;
            else if (m.extra != 0) m.extra = m.extra - 2'd1;
            else if (hz)           m.extra = 2'(lb - 1);
            if (s.id_valid && !stl && !s.flush) begin
                m.ex_valid = 1'b1;
                m.ex_we    = s.id_we;
                m.ex_ld    = s.id_is_load;
                m.ex_dest  = s.id_dest;
                m.opa      = resolve(lb, s.id_ra, s.id_ra_data, s, sa);
                if (s.id_imm_en) m.opb = s.id_imm;
                else             m.opb = resolve(lb, s.id_rb, s.id_rb_data, s, sb);
                m.fa = sa;
                m.fb = sb;
            end else begin
                m.ex_valid = 1'b0;
                m.ex_we    = 1'b0;
                m.ex_ld    = 1'b0;
            end
        end
        ms[k] = m;
        e.s   = m;
    endtask

    task automatic drive(input stim_t s);
        pair_t p;
        @(negedge clk);
        cur = s;
        #1;
        for (int k = 0; k < 2; k++) model_step(k, k + 1, s, p[k]);
        known = 1'b1;
        q.push_back(p);
    endtask

    function automatic stim_t base();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic logic [c_vw-1:0] rand_vec();
        logic [c_vw-1:0] v;
        for (int l = 0; l < c_ln; l++) v[l*c_dw +: c_dw] = $urandom;
        return v;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst         = ($urandom_range(0, 39) != 0);
        s.flush       = ($urandom_range(0, 9) == 0);
        s.id_valid    = ($urandom_range(0, 7) != 0);
        s.id_ra       = 4'($urandom_range(0, 3));
        s.id_rb       = 4'($urandom_range(0, 3));
        s.id_ra_data  = rand_vec();
        s.id_rb_data  = rand_vec();
        s.id_imm_en   = ($urandom_range(0, 3) == 0);
        s.id_imm      = rand_vec();
        s.id_dest     = 4'($urandom_range(0, 3));
        s.id_we       = ($urandom_range(0, 3) != 0);
        s.id_is_load  = ($urandom_range(0, 4) < 2);
        s.mem_dest    = 4'($urandom_range(0, 3));
        s.mem_we      = $urandom_range(0, 1) == 1;
        s.mem_wmask   = 4'($urandom_range(0, 15));
        s.mem_res     = rand_vec();
        s.mem_is_load = $urandom_range(0, 1) == 1;
        s.wb_dest     = 4'($urandom_range(0, 3));
        s.wb_we       = $urandom_range(0, 1) == 1;
        s.wb_wmask    = 4'($urandom_range(0, 15));
        s.wb_res      = rand_vec();
        return s;
    endfunction

    // Monitor: stall is checked mid-cycle, EX registers just after the edge
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                p = q[0];
                for (int k = 0; k < 2; k++)
                    if (p[k].chk_stall) cmp("stall", k, stall_o[k], p[k].stall);
                @(posedge clk);
                #1;
                for (int k = 0; k < 2; k++) begin
                    cmp("ex_valid", k, exv_o[k], p[k].s.ex_valid);
                    cmp("ex_we", k, exwe_o[k], p[k].s.ex_we);
                    cmp("ex_is_load", k, exld_o[k], p[k].s.ex_ld);
                    cmp("ex_dest", k, exd_o[k], p[k].s.ex_dest);
                    cmp("ex_opa", k, opa_o[k], p[k].s.opa);
                    cmp("ex_opb", k, opb_o[k], p[k].s.opb);
                    cmp("fwd_a", k, fa_o[k], p[k].s.fa);
                    cmp("fwd_b", k, fb_o[k], p[k].s.fb);
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        stim_t           s;
        logic [c_vw-1:0] mres;
        ms[0] = '0;
        ms[1] = '0;

        // Reset held two cycles with a valid instruction present
        s = base(); s.rst = 1'b0; s.id_valid = 1'b1; s.id_ra = 4'd2;
        drive(s);
        drive(s);
        for (int k = 0; k < 2; k++) cmp("d_rst_stall", k, stall_o[k], '0);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            cmp("d_rst_valid", k, exv_o[k], '0);
            cmp("d_rst_opa", k, opa_o[k], '0);
        end

        // MEM beats WB beats RF
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd5; s.id_rb = 4'd1;
        s.id_ra_data = {4{32'h10}};
        s.mem_dest = 4'd5; s.mem_we = 1'b1; s.mem_wmask = 4'hF; s.mem_res = {4{32'h15}};
        s.wb_dest  = 4'd5; s.wb_we  = 1'b1; s.wb_wmask  = 4'hF; s.wb_res  = {4{32'h16}};
        drive(s);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            cmp("d_prio_opa", k, opa_o[k], {4{32'h15}});
            cmp("d_prio_fwd_a", k, fa_o[k], 2'd1);
        end

        // Lane mask: upper lanes fall through to WB
        s.mem_wmask = 4'b0011;
        drive(s);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
            cmp("d_mask_opa", k, opa_o[k], {32'h16, 32'h16, 32'h15, 32'h15});

        // Immediate overrides a matching MEM result on operand B
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd1; s.id_rb = 4'd6;
        s.mem_dest = 4'd6; s.mem_we = 1'b1; s.mem_wmask = 4'hF; s.mem_res = rand_vec();
        s.id_imm_en = 1'b1; s.id_imm = 128'h11;
        drive(s);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            cmp("d_imm_opb", k, opb_o[k], 128'h11);
            cmp("d_imm_fwd_b", k, fb_o[k], 2'd3);
        end

        // Load-use with one bubble
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd1; s.id_rb = 4'd1;
        s.id_dest = 4'd3; s.id_we = 1'b1; s.id_is_load = 1'b1;
        drive(s);
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd3; s.id_rb = 4'd1;
        s.id_dest = 4'd4; s.id_we = 1'b1;
        drive(s);
        cmp("d_lu1_stall", 0, stall_o[0], 1'b1);
        @(posedge clk); #1;
        cmp("d_lu1_bubble", 0, exv_o[0], 1'b0);
        mres = rand_vec();
        s.mem_dest = 4'd3; s.mem_we = 1'b1; s.mem_wmask = 4'hF;
        s.mem_is_load = 1'b1; s.mem_res = mres;
        drive(s);
        cmp("d_lu1_release", 0, stall_o[0], 1'b0);
        @(posedge clk); #1;
        cmp("d_lu1_issue", 0, exv_o[0], 1'b1);
        cmp("d_lu1_opa", 0, opa_o[0], mres);

        // Register 0 ignores matching MEM/WB writes
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd0; s.id_rb = 4'd1;
        s.mem_dest = 4'd0; s.mem_we = 1'b1; s.mem_wmask = 4'hF; s.mem_res = '1;
        s.wb_dest  = 4'd0; s.wb_we  = 1'b1; s.wb_wmask  = 4'hF; s.wb_res  = '1;
        drive(s);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) cmp("d_zero_opa", k, opa_o[k], '0);

        // Two bubbles, flush on the hazard cycle
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd1; s.id_rb = 4'd1;
        s.id_dest = 4'd2; s.id_we = 1'b1; s.id_is_load = 1'b1;
        drive(s);
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd2; s.id_rb = 4'd1;
        s.id_dest = 4'd5; s.id_we = 1'b1; s.flush = 1'b1;
        drive(s);
        cmp("d_fl_stall", 1, stall_o[1], 1'b0);
        @(posedge clk); #1;
        cmp("d_fl_valid", 1, exv_o[1], 1'b0);
        s.flush = 1'b0;
        drive(s);
        cmp("d_fl_idle", 1, stall_o[1], 1'b0);
        @(posedge clk); #1;
        cmp("d_fl_issue", 1, exv_o[1], 1'b1);

        // Two bubbles, flush while counting down
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd1; s.id_rb = 4'd1;
        s.id_dest = 4'd2; s.id_we = 1'b1; s.id_is_load = 1'b1;
        drive(s);
        s = base(); s.id_valid = 1'b1; s.id_ra = 4'd1; s.id_rb = 4'd2;
        s.id_dest = 4'd5; s.id_we = 1'b1;
        drive(s);
        cmp("d_lu2_stall", 1, stall_o[1], 1'b1);
        s.flush = 1'b1;
        drive(s);
        cmp("d_lu2_flush", 1, stall_o[1], 1'b0);
        s.flush = 1'b0;
        drive(s);
        cmp("d_lu2_after", 1, stall_o[1], 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) drive(rand_stim());

        s = base();
        for (int i = 0; i < 3; i++) drive(s);
        @(posedge clk); #2;
        cmp("queue_drained", 0, q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
